dmem_io: RTL

Data-memory and memory-mapped I/O stage directly downstream of the LEGLite single-cycle core. Consumes the core's data-memory address, read/write strobes and write data; returns read data in the same cycle, as the single-cycle datapath requires. Holds a word RAM for loads and stores, a synchronized switch input port, a LED output register and an optional compare-match timer.

---
 rtl/dmem_io.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dmem_io.sv
// dmem_io: word RAM, synchronized switch port, LED register and optional
// compare-match timer (enabled by defining DMEM_TIMER_EN) behind a single-cycle load/store port.
module dmem_io #(
    parameter int AW = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] daddr,
    input  logic        dwrite,
    input  logic        dread,
    input  logic [15:0] dwdata,
    output logic [15:0] ddata,
    input  logic [7:0]  switches,
    output logic [7:0]  leds,
    output logic        timer_irq
);

    localparam logic [16:0] RAM_LIMIT  = 17'd2 << AW;
    localparam logic [15:0] ADDR_SW    = 16'hFFF0;
    localparam logic [15:0] ADDR_LED   = 16'hFFF2;
    localparam logic [15:0] ADDR_TCNT  = 16'hFFF4;
    localparam logic [15:0] ADDR_TCTRL = 16'hFFF6;
    localparam logic [15:0] ADDR_TCMP  = 16'hFFF8;
    localparam logic [15:0] ADDR_TSTAT = 16'hFFFA;

    logic [15:0] r_mem [0:(2**AW)-1];
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    logic [7:0]  r_leds;

    logic        w_ram_sel;
    logic [14:0] w_word;
    logic        w_sel_sw;
    logic        w_sel_led;
    logic        w_unused_bit0;
    logic [15:0] w_rdata;

    // Byte address bit 0 never participates in any decode.
    assign w_word        = daddr[15:1];
    assign w_unused_bit0 = daddr[0];
    assign w_ram_sel     = ({1'b0, daddr} < RAM_LIMIT);
    assign w_sel_sw      = (w_word == ADDR_SW[15:1]);
    assign w_sel_led     = (w_word == ADDR_LED[15:1]);

    // RAM has no reset; holding reset low still blocks a store.
    always_ff @(posedge clock) begin
        if (dwrite && w_ram_sel && reset) begin
            r_mem[daddr[AW:1]] <= dwdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= switches;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_leds <= 8'h00;
        end else if (dwrite && w_sel_led) begin
            r_leds <= dwdata[7:0];
        end
    end

    assign leds = r_leds;

`ifdef DMEM_TIMER_EN
    logic [15:0] r_tcnt;
    logic [15:0] r_tcmp;
    logic        r_ten;
    logic        r_flag;

    logic        w_match;
    logic        w_wr_tcnt;
    logic        w_wr_tctrl;
    logic        w_wr_tcmp;
    logic        w_wr_tstat;

    assign w_match    = r_ten && (r_tcnt == r_tcmp);
    assign w_wr_tcnt  = dwrite && (w_word == ADDR_TCNT[15:1]);
    assign w_wr_tctrl = dwrite && (w_word == ADDR_TCTRL[15:1]);
    assign w_wr_tcmp  = dwrite && (w_word == ADDR_TCMP[15:1]);
    assign w_wr_tstat = dwrite && (w_word == ADDR_TSTAT[15:1]);

    // A software store to TCNT wins over counting; a match wins over a clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tcnt <= 16'h0000;
            r_tcmp <= 16'hFFFF;
            r_ten  <= 1'b0;
            r_flag <= 1'b0;
        end else begin
            if (w_wr_tcnt) begin
                r_tcnt <= dwdata;
            end else if (r_ten) begin
                r_tcnt <= w_match ? 16'h0000 : (r_tcnt + 16'd1);
            end
            if (w_wr_tctrl) begin
                r_ten <= dwdata[0];
            end
            if (w_wr_tcmp) begin
                r_tcmp <= dwdata;
            end
            if (w_match) begin
                r_flag <= 1'b1;
            end else if (w_wr_tstat && dwdata[0]) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign timer_irq = r_flag;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        w_rdata = 16'h0000;
        if (w_ram_sel) begin
            w_rdata = r_mem[daddr[AW:1]];
        end else if (w_sel_sw) begin
            w_rdata = {8'h00, r_sw_sync};
        end else if (w_sel_led) begin
            w_rdata = {8'h00, r_leds};
`ifdef DMEM_TIMER_EN
        end else if (w_word == ADDR_TCNT[15:1]) begin
            w_rdata = r_tcnt;
        end else if (w_word == ADDR_TCTRL[15:1]) begin
            w_rdata = {15'h0000, r_ten};
        end else if (w_word == ADDR_TCMP[15:1]) begin
            w_rdata = r_tcmp;
        end else if (w_word == ADDR_TSTAT[15:1]) begin
            w_rdata = {15'h0000, r_flag};
`endif
        end
    end

    assign ddata = dread ? w_rdata : 16'h0000;

endmodule
